// File: rtl/irda_rx_frame.sv
// IrDA SIR frame receiver: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define IRDA_RX_PARITY_EN to compile in an even-parity bit between the data and the stop bit.

module irda_rx_frame (
  input  logic       clk,
  input  logic       reset,
  input  logic       irda_rx_n,
  input  logic       delay_pulse,
  input  logic       done_pulse,
  output logic       baud_rst,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

`ifdef IRDA_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state_q, state_d;
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  logic       rx_prev_q, rx_prev_d;
  logic       pulse_seen_q, pulse_seen_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       fall;
  logic       bit_val;
  logic       parity_ok;
`ifdef IRDA_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_q, parity_err_d;
`endif

  assign fall    = rx_prev_q & ~rx_s_q;
  // A bit reads 0 if a pulse was caught anywhere in its period, including the closing cycle.
  assign bit_val = ~pulse_seen_q & rx_s_q;

`ifdef IRDA_RX_PARITY_EN
  assign parity_ok  = ~(^{shift_q, par_q});
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START: begin
        if (delay_pulse && rx_s_q) state_d = IDLE;
        else if (done_pulse)       state_d = DATA;
      end
`ifdef IRDA_RX_PARITY_EN
      DATA:   if (done_pulse && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY: if (done_pulse) state_d = STOP;
`else
      DATA:   if (done_pulse && bit_cnt_q == 3'd7) state_d = STOP;
`endif
      STOP:   if (done_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_rst = (state_q == IDLE);
    rx_busy  = (state_q != IDLE);
  end

  always_comb begin
    rx_meta_d    = irda_rx_n;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    pulse_seen_d = pulse_seen_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef IRDA_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (done_pulse)                          pulse_seen_d = 1'b0;
    else if (state_q != IDLE && !rx_s_q)     pulse_seen_d = 1'b1;

    if (done_pulse) begin
      case (state_q)
        START: bit_cnt_d = 3'd0;
        DATA: begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
`ifdef IRDA_RX_PARITY_EN
        PARITY: par_d = bit_val;
`endif
        STOP: begin
          if (!bit_val) begin
            frame_err_d = 1'b1;
          end else if (parity_ok) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end
`ifdef IRDA_RX_PARITY_EN
          parity_err_d = ~parity_ok;
`endif
        end
        default: ;
      endcase
    end
  end

  // Synchronizer resets to the idle line level so reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      pulse_seen_q <= 1'b0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef IRDA_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      pulse_seen_q <= pulse_seen_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef IRDA_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_irda_rx_frame.sv
// Self-checking bench for irda_rx_frame: baud counter model, IrDA pulse driver, table plus random frames.
// Build with IRDA_RX_PARITY_EN defined to exercise the parity variant.

module tb_irda_rx_frame;

  localparam int PULSE       = 244;
  localparam int DONE_BUDGET = 1400;
`ifdef IRDA_RX_PARITY_EN
  localparam int FRAME_BITS  = 10;
  localparam int NUM_RAND    = 0;
`else
  localparam int FRAME_BITS  = 9;
  localparam int NUM_RAND    = 2;
`endif

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_ok;
    bit         exp_valid;
    bit         exp_ferr;
    bit         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       irda_rx_n;
  logic       delay_pulse;
  logic       done_pulse;
  logic       baud_rst;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  logic [10:0] baud_cnt = 11'd0;
  int          passed = 0;
  int          total = 0;
  int          dv_cycles = 0;
  int          fe_cycles = 0;
  int          pe_cycles = 0;
  logic [7:0]  model_data;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  irda_rx_frame dut (
    .clk        (clk),
    .reset      (reset),
    .irda_rx_n  (irda_rx_n),
    .delay_pulse(delay_pulse),
    .done_pulse (done_pulse),
    .baud_rst   (baud_rst),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  // Baud counter: held at 0 by baud_rst, 1302-clock bit period, delay strobe 60 clocks in.
  always @(posedge clk) begin
    if (baud_rst === 1'b1)      baud_cnt <= 11'd0;
    else if (baud_cnt == 11'd1301) baud_cnt <= 11'd0;
    else                        baud_cnt <= baud_cnt + 11'd1;
  end
  assign delay_pulse = (baud_rst === 1'b0) && (baud_cnt == 11'd60);
  assign done_pulse  = (baud_rst === 1'b0) && (baud_cnt == 11'd1301);

  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cycles++;
    if (frame_err === 1'b1)  fe_cycles++;
    if (parity_err === 1'b1) pe_cycles++;
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: run still active, required to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  task automatic waitDone(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_pulse !== 1'b1 && n < DONE_BUDGET);
    ok = (done_pulse === 1'b1);
    if (!ok) begin
      total++;
      $display("[TB] FAIL done_wait: no done_pulse in %0d cycles, required one", n);
    end
  endtask

  task automatic drivePulse();
    irda_rx_n = 1'b0;
    repeat (PULSE) @(negedge clk);
    irda_rx_n = 1'b1;
  endtask

  // Start pulse, then nbits bit periods; pulses sit at a random point inside each period.
  task automatic sendBits(input string name, input logic [10:0] frame, input int nbits, output bit ok);
    ok = 1'b1;
    drivePulse();
    checkOutput({name, "_busy"}, {31'd0, rx_busy}, 32'd1);
    checkOutput({name, "_baud_rst"}, {31'd0, baud_rst}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      waitDone(ok);
      if (!ok) return;
      repeat ($urandom_range(100, 900)) @(negedge clk);
      if (frame[i] == 1'b0) drivePulse();
    end
    waitDone(ok);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [10:0] frame;
    bit          ok;
    int          dv0, fe0, pe0, dd, fd, pd;
    dv0 = dv_cycles;
    fe0 = fe_cycles;
    pe0 = pe_cycles;
`ifdef IRDA_RX_PARITY_EN
    frame = {1'b0, v.stop_ok, v.par_bit, v.data};
`else
    frame = {2'b00, v.stop_ok, v.data};
`endif
    sendBits(v.name, frame, FRAME_BITS, ok);
    if (ok) begin
      @(negedge clk);
      checkOutput({v.name, "_valid"}, {31'd0, data_valid}, {31'd0, v.exp_valid});
      checkOutput({v.name, "_frame_err"}, {31'd0, frame_err}, {31'd0, v.exp_ferr});
      checkOutput({v.name, "_parity_err"}, {31'd0, parity_err}, {31'd0, v.exp_perr});
      checkOutput({v.name, "_data_out"}, {24'd0, data_out}, {24'd0, v.exp_data});
      checkOutput({v.name, "_idle_after"}, {30'd0, rx_busy, baud_rst}, 32'd1);
      @(negedge clk);
      checkOutput({v.name, "_strobes_cleared"}, {29'd0, data_valid, frame_err, parity_err}, 32'd0);
      dd = dv_cycles - dv0;
      fd = fe_cycles - fe0;
      pd = pe_cycles - pe0;
      checkOutput({v.name, "_strobe_cycles"}, (dd << 16) | (fd << 8) | pd,
                  ({31'd0, v.exp_valid} << 16) | ({31'd0, v.exp_ferr} << 8) | {31'd0, v.exp_perr});
    end
    repeat ($urandom_range(20, 80)) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n, s0;
    logic [10:0] partial;

    vecs.push_back('{"a5_ok",       8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{"3c_stop_err", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5});
`ifdef IRDA_RX_PARITY_EN
    vecs.push_back('{"07_par1",     8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{"07_par0",     8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07});
`endif

    reset     = 1'b1;
    irda_rx_n = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset_baud_rst", {31'd0, baud_rst}, 32'd1);
    checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
    model_data = 8'h00;
    repeat (10) @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      model_data = vecs[i].exp_data;
    end

    // A short glitch starts a frame that must be abandoned at the delay strobe.
    s0 = dv_cycles + fe_cycles + pe_cycles;
    irda_rx_n = 1'b0;
    repeat (10) @(negedge clk);
    irda_rx_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("glitch_busy", {31'd0, rx_busy}, 32'd1);
    n = 0;
    while (baud_rst !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("glitch_back_idle", {31'd0, baud_rst}, 32'd1);
    checkOutput("glitch_return_time", {31'd0, (n >= 30 && n <= 70)}, 32'd1);
    checkOutput("glitch_no_strobe", dv_cycles + fe_cycles + pe_cycles - s0, 32'd0);
    checkOutput("glitch_data_out", {24'd0, data_out}, {24'd0, model_data});
    repeat (20) @(negedge clk);

    // Reset pulse while data bit 4 of 0x5A is in progress.
    s0 = dv_cycles + fe_cycles + pe_cycles;
    partial = {3'b000, 8'h5A};
    sendBits("rst_mid", partial, 4, ok);
    if (ok) begin
      repeat (50) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_mid_baud_rst", {31'd0, baud_rst}, 32'd1);
      checkOutput("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
      checkOutput("rst_mid_data_out", {24'd0, data_out}, 32'd0);
      checkOutput("rst_mid_strobes", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
      repeat (2000) @(negedge clk);
      checkOutput("rst_mid_no_strobe", dv_cycles + fe_cycles + pe_cycles - s0, 32'd0);
      model_data = 8'h00;
    end
    reset = 1'b0;
    applyStimulus('{"81_after_rst", 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81});
    model_data = 8'h81;

    // Random frames judged by the frame-level rules: stop bit first, then parity.
    for (int i = 0; i < NUM_RAND; i++) begin
      vec_t v;
      bit   par_good;
      v.name     = $sformatf("rand%0d", i);
      v.data     = 8'($urandom_range(0, 255));
      v.stop_ok  = ($urandom_range(0, 3) != 0);
      par_good   = ($urandom_range(0, 1) == 1);
      v.par_bit  = par_good ? ^v.data : ~^v.data;
`ifdef IRDA_RX_PARITY_EN
      v.exp_perr  = !par_good;
      v.exp_valid = v.stop_ok && par_good;
`else
      v.exp_perr  = 1'b0;
      v.exp_valid = v.stop_ok;
`endif
      v.exp_ferr = !v.stop_ok;
      v.exp_data = v.exp_valid ? v.data : model_data;
      applyStimulus(v);
      model_data = v.exp_data;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
